// File: rtl/mmm_job_sequencer.sv
// Job-level sequencer for the matrix-multiply core.
// It accepts one job descriptor at a time, runs its tiles back-to-back with a
// one-cycle start pulse per tile, and generates per-tile SRAM base addresses.
// A job ends in DONE with status OK, TIMEOUT or ABORT, and the result is held
// there until it is consumed.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. in_ready and out_valid come straight from the state register,
// so they never depend combinationally on the partner's valid/ready.
module mmm_job_sequencer #(
   parameter int NUM_RD_CH = 4,
   parameter int ADDR_W    = 10,
   parameter int TILE_W    = 8,
   parameter int RD_STRIDE = 16,
   parameter int WR_STRIDE = 8,
   parameter int TIMEOUT   = 1023
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [TILE_W-1:0]             in_num_tiles,
   input  logic [NUM_RD_CH*ADDR_W-1:0]   in_rd_base,
   input  logic [ADDR_W-1:0]             in_wr_base,
   output logic                          core_start,
   input  logic                          core_done,
   output logic [NUM_RD_CH*ADDR_W-1:0]   core_rd_base,
   output logic [ADDR_W-1:0]             core_wr_base,
   input  logic                          abort,
   output logic                          busy,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [1:0]                    out_status,
   output logic [TILE_W-1:0]             out_tiles_done,
   output logic [1:0]                    dbg_state
);

   // Watchdog is wide enough to count up to TIMEOUT; a 1-bit stub when disabled.
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0]   WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
   localparam logic [ADDR_W-1:0] RD_INC  = ADDR_W'(RD_STRIDE);
   localparam logic [ADDR_W-1:0] WR_INC  = ADDR_W'(WR_STRIDE);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                        state_q, state_d;
   logic [TILE_W-1:0]             num_q, num_d;
   logic [TILE_W-1:0]             idx_q, idx_d;
   logic [TILE_W-1:0]             tiles_done_q, tiles_done_d;
   logic [1:0]                    status_q, status_d;
   logic [WD_W-1:0]               wdog_q, wdog_d;
   logic [NUM_RD_CH*ADDR_W-1:0]   rd_q, rd_d;
   logic [ADDR_W-1:0]             wr_q, wr_d;
   logic [TILE_W-1:0]             idx_inc;

   // State and datapath registers; everything returns to zero/IDLE on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         num_q        <= '0;
         idx_q        <= '0;
         tiles_done_q <= '0;
         status_q     <= ST_OK;
         wdog_q       <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         idx_q        <= idx_d;
         tiles_done_q <= tiles_done_d;
         status_q     <= status_d;
         wdog_q       <= wdog_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
      end
   end

   // Next-state logic: accept, per-tile start/wait loop, and result hold.
   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      idx_d        = idx_q;
      tiles_done_d = tiles_done_q;
      status_d     = status_q;
      wdog_d       = wdog_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      idx_inc      = idx_q + TILE_W'(1);

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Bases for tile 0 are the descriptor bases themselves.
               num_d        = in_num_tiles;
               idx_d        = '0;
               rd_d         = in_rd_base;
               wr_d         = in_wr_base;
               wdog_d       = '0;
               status_d     = ST_OK;
               tiles_done_d = '0;
               if (in_num_tiles == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_START;
               end
            end
         end

         S_START: begin
            wdog_d = '0;
            if (abort) begin
               state_d      = S_DONE;
               status_d     = ST_ABORT;
               tiles_done_d = idx_q;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (abort) begin
               state_d      = S_DONE;
               status_d     = ST_ABORT;
               tiles_done_d = idx_q;
            end else if (core_done) begin
               idx_d = idx_inc;
               if (idx_inc == num_q) begin
                  state_d      = S_DONE;
                  status_d     = ST_OK;
                  tiles_done_d = num_q;
               end else begin
                  // Stepping the bases by the stride each tile equals
                  // base + idx*stride modulo 2^ADDR_W.
                  state_d = S_START;
                  for (int k = 0; k < NUM_RD_CH; k++) begin
                     rd_d[k*ADDR_W +: ADDR_W] = rd_q[k*ADDR_W +: ADDR_W] + RD_INC;
                  end
                  wr_d = wr_q + WR_INC;
               end
            end else if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
               // This WAIT cycle is the TIMEOUT-th without a done.
               state_d      = S_DONE;
               status_d     = ST_TIMEOUT;
               tiles_done_d = idx_q;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from state or driven directly from registers.
   always_comb begin
      in_ready       = (state_q == S_IDLE);
      busy           = (state_q != S_IDLE);
      core_start     = (state_q == S_START);
      out_valid      = (state_q == S_DONE);
      out_status     = status_q;
      out_tiles_done = tiles_done_q;
      core_rd_base   = rd_q;
      core_wr_base   = wr_q;
      dbg_state      = state_q;
   end

endmodule

// File: tb/tb_mmm_job_sequencer.sv
// Bench for mmm_job_sequencer: directed jobs, expected start bases and job
// results queued when stimulus is issued, a negedge monitor popping and
// comparing them, and a final summary line.
module tb_mmm_job_sequencer;

   localparam int NUM_RD_CH = 4;
   localparam int ADDR_W    = 10;
   localparam int TILE_W    = 8;
   localparam int RD_STRIDE = 16;
   localparam int WR_STRIDE = 8;
   localparam int TIMEOUT   = 8;
   localparam int RD_W      = NUM_RD_CH * ADDR_W;
   localparam int SW        = RD_W + ADDR_W;
   localparam int RW        = 2 + TILE_W;

   logic                clock = 1'b0;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic [TILE_W-1:0]   in_num_tiles;
   logic [RD_W-1:0]     in_rd_base;
   logic [ADDR_W-1:0]   in_wr_base;
   logic                core_start;
   logic                core_done;
   logic [RD_W-1:0]     core_rd_base;
   logic [ADDR_W-1:0]   core_wr_base;
   logic                abort;
   logic                busy;
   logic                out_valid;
   logic                out_ready;
   logic [1:0]          out_status;
   logic [TILE_W-1:0]   out_tiles_done;
   logic [1:0]          dbg_state;

   int total = 0;
   int bad   = 0;

   logic [SW-1:0] exp_start_q[$];
   logic [RW-1:0] exp_res_q[$];
   logic [SW-1:0] mon_start_exp;
   logic [RW-1:0] mon_res_exp;

   mmm_job_sequencer #(
      .NUM_RD_CH (NUM_RD_CH),
      .ADDR_W    (ADDR_W),
      .TILE_W    (TILE_W),
      .RD_STRIDE (RD_STRIDE),
      .WR_STRIDE (WR_STRIDE),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_num_tiles   (in_num_tiles),
      .in_rd_base     (in_rd_base),
      .in_wr_base     (in_wr_base),
      .core_start     (core_start),
      .core_done      (core_done),
      .core_rd_base   (core_rd_base),
      .core_wr_base   (core_wr_base),
      .abort          (abort),
      .busy           (busy),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_status     (out_status),
      .out_tiles_done (out_tiles_done),
      .dbg_state      (dbg_state)
   );

   // Clock
   always #5 clock = ~clock;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got still running want finished");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [RD_W-1:0] pack_rd(input int c0, input int c1, input int c2, input int c3);
      return {ADDR_W'(c3), ADDR_W'(c2), ADDR_W'(c1), ADDR_W'(c0)};
   endfunction

   task automatic push_start(input logic [RD_W-1:0] rd, input logic [ADDR_W-1:0] wr);
      exp_start_q.push_back({rd, wr});
   endtask

   task automatic push_res(input logic [1:0] st, input logic [TILE_W-1:0] n);
      exp_res_q.push_back({st, n});
   endtask

   // Monitor: compares every start pulse and every consumed result.
   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (core_start === 1'b1) begin
            if (exp_start_q.size() == 0) begin
               check("unexpected_core_start", 64'(core_start), 64'(0));
            end else begin
               mon_start_exp = exp_start_q.pop_front();
               check("start_bases", 64'({core_rd_base, core_wr_base}), 64'(mon_start_exp));
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_res_q.size() == 0) begin
               check("unexpected_result", 64'(out_valid), 64'(0));
            end else begin
               mon_res_exp = exp_res_q.pop_front();
               check("job_result", 64'({out_status, out_tiles_done}), 64'(mon_res_exp));
            end
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_job(input logic [TILE_W-1:0] n, input logic [RD_W-1:0] rd, input logic [ADDR_W-1:0] wr);
      check("in_ready_before_accept", 64'(in_ready), 64'(1));
      in_valid     = 1'b1;
      in_num_tiles = n;
      in_rd_base   = rd;
      in_wr_base   = wr;
      tick();
      in_valid     = 1'b0;
   endtask

   task automatic wait_start(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (core_start === 1'b1) found = 1'b1;
         else tick();
      end
      check(name, 64'(found), 64'(1));
   endtask

   task automatic wait_valid(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (out_valid === 1'b1) found = 1'b1;
         else tick();
      end
      check(name, 64'(found), 64'(1));
   endtask

   task automatic pulse_done(input int delay);
      repeat (delay) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
   endtask

   // Directed stimulus
   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_num_tiles = '0;
      in_rd_base   = '0;
      in_wr_base   = '0;
      core_done    = 1'b0;
      abort        = 1'b0;
      out_ready    = 1'b1;
      #2;
      check("reset_ctrl", 64'({in_ready, busy, core_start, out_valid, out_status, out_tiles_done}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0}));
      check("reset_bases", 64'({core_rd_base, core_wr_base}), 64'(0));
      check("reset_state", 64'(dbg_state), 64'(0));
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      tick();

      // 1: three tiles, done 5 cycles after each start.
      push_start(pack_rd(0, 100, 200, 300), 10'd50);
      push_start(pack_rd(16, 116, 216, 316), 10'd58);
      push_start(pack_rd(32, 132, 232, 332), 10'd66);
      push_res(2'b00, 8'd3);
      send_job(8'd3, pack_rd(0, 100, 200, 300), 10'd50);
      check("t1_start_after_accept", 64'(core_start), 64'(1));
      check("t1_busy", 64'({busy, in_ready}), 64'({1'b1, 1'b0}));
      for (int t = 0; t < 3; t++) begin
         wait_start("t1_wait_start");
         pulse_done(5);
      end
      wait_valid("t1_wait_valid");
      tick();
      check("t1_in_ready_after", 64'(in_ready), 64'(1));

      // 2: zero tiles -> result next cycle, no start.
      push_res(2'b00, 8'd0);
      send_job(8'd0, pack_rd(5, 6, 7, 8), 10'd9);
      check("t2_valid_next_cycle", 64'({out_valid, core_start}), 64'({1'b1, 1'b0}));
      tick();
      check("t2_in_ready_after", 64'(in_ready), 64'(1));

      // 3: four tiles, second tile never completes -> timeout after 8 WAIT cycles.
      push_start(pack_rd(10, 20, 30, 40), 10'd0);
      push_start(pack_rd(26, 36, 46, 56), 10'd8);
      push_res(2'b01, 8'd1);
      send_job(8'd4, pack_rd(10, 20, 30, 40), 10'd0);
      wait_start("t3_wait_start0");
      pulse_done(3);
      wait_start("t3_wait_start1");
      repeat (8) tick();
      check("t3_still_waiting", 64'({out_valid, dbg_state}), 64'({1'b0, 2'd2}));
      tick();
      check("t3_timeout_done", 64'(out_valid), 64'(1));
      tick();
      check("t3_in_ready_after", 64'(in_ready), 64'(1));

      // 4: abort and core_done together on tile 0 of 2.
      push_start(pack_rd(1, 2, 3, 4), 10'd5);
      push_res(2'b10, 8'd0);
      send_job(8'd2, pack_rd(1, 2, 3, 4), 10'd5);
      wait_start("t4_wait_start");
      tick();
      tick();
      abort     = 1'b1;
      core_done = 1'b1;
      tick();
      abort     = 1'b0;
      core_done = 1'b0;
      check("t4_abort_done", 64'(out_valid), 64'(1));
      tick();
      repeat (3) tick();
      check("t4_idle_after", 64'({in_ready, busy}), 64'({1'b1, 1'b0}));

      // 5: address wrap on ch0 and write base.
      push_start(pack_rd(1020, 0, 0, 0), 10'd1020);
      push_start(pack_rd(12, 16, 16, 16), 10'd4);
      push_res(2'b00, 8'd2);
      send_job(8'd2, pack_rd(1020, 0, 0, 0), 10'd1020);
      wait_start("t5_wait_start0");
      pulse_done(1);
      wait_start("t5_wait_start1");
      pulse_done(1);
      wait_valid("t5_wait_valid");
      tick();

      // 6: result held with out_ready low; new descriptor ignored meanwhile.
      push_start(pack_rd(7, 7, 7, 7), 10'd9);
      push_res(2'b00, 8'd1);
      out_ready = 1'b0;
      send_job(8'd1, pack_rd(7, 7, 7, 7), 10'd9);
      wait_start("t6_wait_start");
      pulse_done(2);
      wait_valid("t6_wait_valid");
      in_valid     = 1'b1;
      in_num_tiles = 8'd5;
      for (int i = 0; i < 20; i++) begin
         check("t6_hold", 64'({out_valid, in_ready, out_status, out_tiles_done}),
               64'({1'b1, 1'b0, 2'b00, 8'd1}));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t6_in_ready_after", 64'(in_ready), 64'(1));

      // Reset in the middle of WAIT: immediate return to reset values.
      push_start(pack_rd(3, 3, 3, 3), 10'd3);
      send_job(8'd3, pack_rd(3, 3, 3, 3), 10'd3);
      wait_start("rst_wait_start");
      tick();
      tick();
      check("rst_pre_wait", 64'(dbg_state), 64'(2));
      reset = 1'b1;
      #1;
      check("rst_mid_ctrl", 64'({in_ready, busy, core_start, out_valid, out_status, out_tiles_done}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0}));
      check("rst_mid_bases", 64'({core_rd_base, core_wr_base}), 64'(0));
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (5) tick();
      check("rst_no_result", 64'(out_valid), 64'(0));

      check("start_q_empty", 64'(exp_start_q.size()), 64'(0));
      check("res_q_empty", 64'(exp_res_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
